// File: rtl/lobinho_pkg.sv
// Shared types and constants for the game blocks: vote FSM states, player index type
// and the abstention code.
package lobinho_pkg;

  localparam int NUM_JOGADORES = 5;

  typedef logic [2:0] jogador_t;

  localparam jogador_t VOTO_NULO = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO,
    COLETA,
    APURACAO,
    FIM
  } estado_votacao_t;

endpackage

// File: rtl/proximo_vivo.sv
// Combinational search for the next alive player above the current index, or the
// lowest alive player when no current index is given.
module proximo_vivo #(
  parameter int NUM_JOGADORES = lobinho_pkg::NUM_JOGADORES
) (
  input  logic [NUM_JOGADORES-1:0] vivos,
  input  logic [2:0]               atual,
  input  logic                     tem_atual,
  output logic [2:0]               proximo,
  output logic                     ultimo
);

  // Scanning downwards leaves the lowest qualifying index as the final answer.
  always_comb begin
    proximo = '0;
    ultimo  = 1'b1;
    for (int i = NUM_JOGADORES - 1; i >= 0; i--) begin
      if (vivos[i] && (!tem_atual || i > int'(atual))) begin
        proximo = 3'(i);
        ultimo  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/urna_votacao.sv
// Ballot box: collects one vote per alive player in index order, then scans the tally
// to report the eliminated player or a tie. Define VOTO_NULO_EN to accept 3'b111 as abstention.
module urna_votacao #(
  parameter int NUM_JOGADORES = lobinho_pkg::NUM_JOGADORES,
  parameter int LARGURA_CONT  = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [NUM_JOGADORES-1:0] vivos,
  input  logic                     voto_valido,
  input  logic [2:0]               jogador_escolhido,
  output logic [2:0]               votante_atual,
  output logic                     coletando,
  output logic                     voto_aceito,
  output logic                     voto_rejeitado,
  output logic                     pronto,
  output logic [2:0]               eliminado,
  output logic                     empate
);

  import lobinho_pkg::*;

  estado_votacao_t estado, estado_prox;

  logic [NUM_JOGADORES-1:0] vivos_lat;
  logic [LARGURA_CONT-1:0]  cont [NUM_JOGADORES];
  logic [LARGURA_CONT-1:0]  max_cont;
  logic [LARGURA_CONT-1:0]  cont_scan;
  jogador_t                 indice_scan;
  jogador_t                 primeiro_vivo;
  jogador_t                 proximo_votante;
  logic                     nenhum_vivo;
  logic                     ultimo_votante;
  logic                     alvo_vivo;
  logic                     eh_nulo;
  logic                     aceita;

  proximo_vivo #(.NUM_JOGADORES(NUM_JOGADORES)) u_inicio (
    .vivos     (vivos),
    .atual     (3'd0),
    .tem_atual (1'b0),
    .proximo   (primeiro_vivo),
    .ultimo    (nenhum_vivo)
  );

  proximo_vivo #(.NUM_JOGADORES(NUM_JOGADORES)) u_avanco (
    .vivos     (vivos_lat),
    .atual     (votante_atual),
    .tem_atual (1'b1),
    .proximo   (proximo_votante),
    .ultimo    (ultimo_votante)
  );

  // Compare-by-loop keeps out-of-range targets (5..7) from indexing past the mask.
  always_comb begin
    alvo_vivo = 1'b0;
    cont_scan = '0;
    for (int i = 0; i < NUM_JOGADORES; i++) begin
      if (int'(jogador_escolhido) == i && vivos_lat[i]) alvo_vivo = 1'b1;
      if (int'(indice_scan) == i) cont_scan = cont[i];
    end
  end

`ifdef VOTO_NULO_EN
  assign eh_nulo = (jogador_escolhido == VOTO_NULO);
`else
  assign eh_nulo = 1'b0;
`endif

  assign aceita    = alvo_vivo | eh_nulo;
  assign coletando = (estado == COLETA);
  assign pronto    = (estado == FIM);

  always_ff @(posedge clock) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    if (iniciar) begin
      estado_prox = nenhum_vivo ? APURACAO : COLETA;
    end else begin
      case (estado)
        COLETA:   if (voto_valido && aceita && ultimo_votante) estado_prox = APURACAO;
        APURACAO: if (int'(indice_scan) == NUM_JOGADORES - 1) estado_prox = FIM;
        default:  estado_prox = estado;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vivos_lat      <= '0;
      votante_atual  <= '0;
      voto_aceito    <= 1'b0;
      voto_rejeitado <= 1'b0;
      eliminado      <= '0;
      empate         <= 1'b0;
      max_cont       <= '0;
      indice_scan    <= '0;
      for (int i = 0; i < NUM_JOGADORES; i++) cont[i] <= '0;
    end else begin
      voto_aceito    <= 1'b0;
      voto_rejeitado <= 1'b0;
      if (iniciar) begin
        vivos_lat     <= vivos;
        votante_atual <= primeiro_vivo;
        eliminado     <= '0;
        empate        <= 1'b0;
        max_cont      <= '0;
        indice_scan   <= '0;
        for (int i = 0; i < NUM_JOGADORES; i++) cont[i] <= '0;
      end else begin
        case (estado)
          COLETA: begin
            if (voto_valido) begin
              if (aceita) begin
                voto_aceito <= 1'b1;
                for (int i = 0; i < NUM_JOGADORES; i++) begin
                  if (!eh_nulo && int'(jogador_escolhido) == i) cont[i] <= cont[i] + 1'b1;
                end
                if (!ultimo_votante) votante_atual <= proximo_votante;
                indice_scan <= '0;
              end else begin
                voto_rejeitado <= 1'b1;
              end
            end
          end
          // Index 0 seeds the running max against an implicit max of 0 with empate set.
          APURACAO: begin
            if (indice_scan == '0) begin
              max_cont  <= cont_scan;
              eliminado <= '0;
              empate    <= (cont_scan == '0);
            end else if (cont_scan > max_cont) begin
              max_cont  <= cont_scan;
              eliminado <= indice_scan;
              empate    <= 1'b0;
            end else if (cont_scan == max_cont) begin
              empate    <= 1'b1;
            end
            indice_scan <= indice_scan + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
